// File: rtl/adder_core.sv
// Registered two-operand adder/subtractor with a two-level carry-lookahead datapath.
// Sum and status flags are captured together one cycle after an accepted operation.
module adder_core #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CLA_BLOCK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             out_valid
);

  localparam int unsigned NG = WIDTH / CLA_BLOCK;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] sum;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;
  logic             sum_cout;
  logic             sum_ovf;

  always_comb begin
    b_eff = sub ? ~b : b;
    g     = a & b_eff;
    p     = a ^ b_eff;
  end

  // Level 1: group generate/propagate over each CLA_BLOCK slice.
  always_comb begin
    logic gacc;
    logic pacc;
    grp_g = '0;
    grp_p = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int unsigned j = 0; j < CLA_BLOCK; j++) begin
        gacc = g[k*CLA_BLOCK + j] | (p[k*CLA_BLOCK + j] & gacc);
        pacc = pacc & p[k*CLA_BLOCK + j];
      end
      grp_g[k] = gacc;
      grp_p[k] = pacc;
    end
  end

  // Level 2: each group carry is formed independently from cin and all lower G/P terms.
  always_comb begin
    logic cacc;
    grp_c    = '0;
    grp_c[0] = sub;
    for (int unsigned k = 0; k < NG; k++) begin
      cacc = sub;
      for (int unsigned m = 0; m <= k; m++) begin
        cacc = grp_g[m] | (grp_p[m] & cacc);
      end
      grp_c[k+1] = cacc;
    end
  end

  always_comb begin
    logic cbit;
    c = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      cbit = grp_c[k];
      for (int unsigned j = 0; j < CLA_BLOCK; j++) begin
        c[k*CLA_BLOCK + j] = cbit;
        cbit = g[k*CLA_BLOCK + j] | (p[k*CLA_BLOCK + j] & cbit);
      end
    end
    sum      = p ^ c;
    sum_cout = grp_c[NG];
    sum_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result    <= sum;
        carry_out <= sum_cout;
        overflow  <= sum_ovf;
        zero      <= (sum == '0);
        negative  <= sum[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_core.sv
// Randomized self-checking bench for adder_core against an arithmetic reference model.
module tb_adder_core;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         negative;
  logic         out_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [W-1:0] m_res;
  logic         m_c;
  logic         m_ov;
  logic         m_z;
  logic         m_n;
  logic         m_v;

  always #5 clk = ~clk;

  adder_core #(.WIDTH(W), .CLA_BLOCK(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative),
    .out_valid (out_valid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit unsigned and signed arithmetic on the operands.
  task automatic model_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint unsigned ux;
    longint unsigned uy;
    longint unsigned ur;
    longint          sx;
    longint          sy;
    longint          exact;
    longint          lim;
    ux    = {32'd0, x};
    uy    = {32'd0, y};
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    lim   = 64'sd2147483648;
    ur    = s ? (ux - uy) : (ux + uy);
    exact = s ? (sx - sy) : (sx + sy);
    m_res = ur[W-1:0];
    m_c   = s ? (ux >= uy) : ((ux + uy) > 64'hFFFF_FFFF);
    m_ov  = (exact >= lim) || (exact < -lim);
    m_z   = (m_res == 0);
    m_n   = (exact < 0) ^ m_ov;
    m_v   = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/result"},    64'(result),    64'(m_res));
    check({tag, "/carry_out"}, 64'(carry_out), 64'(m_c));
    check({tag, "/overflow"},  64'(overflow),  64'(m_ov));
    check({tag, "/zero"},      64'(zero),      64'(m_z));
    check({tag, "/negative"},  64'(negative),  64'(m_n));
    check({tag, "/out_valid"}, 64'(out_valid), 64'(m_v));
  endtask

  task automatic model_clear();
    m_res = '0;
    m_c   = 1'b0;
    m_ov  = 1'b0;
    m_z   = 1'b0;
    m_n   = 1'b0;
    m_v   = 1'b0;
  endtask

  task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input logic v, input string tag);
    @(negedge clk);
    a        = x;
    b        = y;
    sub      = s;
    in_valid = v;
    @(posedge clk);
    if (v) model_op(x, y, s);
    else   m_v = 1'b0;
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 32'd1;
      2:       v = '1;
      3:       v = 32'h7FFF_FFFF;
      4:       v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;
    model_clear();
    #2 reset = 1'b1;
    #1 check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    apply(32'd1,         32'd1 + 32'd1, 1'b0, 1'b1, "add_1_2");
    apply(32'd10,        32'd10,        1'b0, 1'b1, "add_10_10");
    apply(32'h7FFF_FFFF, 32'd1,         1'b0, 1'b1, "add_sovf");
    check("add_sovf/abs_result", 64'(result), 64'h8000_0000);
    apply(32'hFFFF_FFFF, 32'd1,         1'b0, 1'b1, "add_wrap");
    check("add_wrap/abs_zero", 64'(zero), 64'd1);
    apply(32'd5,         32'd7,         1'b1, 1'b1, "sub_5_7");
    check("sub_5_7/abs_result", 64'(result), 64'hFFFF_FFFE);
    apply(32'd7,         32'd7,         1'b1, 1'b1, "sub_7_7");
    apply(32'h8000_0000, 32'd1,         1'b1, 1'b1, "sub_sovf");
    apply(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, "idle_hold");

    // Reset lands between edges while a freshly accepted operation is pending.
    apply(32'd100, 32'd23, 1'b0, 1'b1, "pre_reset");
    @(negedge clk);
    a        = 32'd3;
    b        = 32'd4;
    sub      = 1'b0;
    in_valid = 1'b1;
    #2 reset = 1'b1;
    model_clear();
    #1 check_outputs("async_reset");
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 check_outputs("post_reset_idle");
    apply(32'd40, 32'd2, 1'b0, 1'b1, "post_reset_op");

    for (int i = 0; i < 10000; i++) begin
      apply(pick(), pick(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
